// File: rtl/sp_fp_pkg.sv
// Single-precision field layout and special encodings shared by the sradd datapath.
package sp_fp_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_HI   = 30;
    localparam int EXP_LO   = 23;
    localparam int MANT_HI  = 22;
    localparam int MANT_LO  = 0;

    localparam logic [31:0] ZERO = 32'h0000_0000;
    localparam logic [31:0] NAN  = 32'hFFFF_FFFF;
    localparam int          BIAS = 127;
    localparam logic [7:0]  EMAX = 8'hFF;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } sp_t;

endpackage

// File: rtl/sradd_lzc.sv
// Leading-zero counter: number of zeros above the most significant set bit (28 when all zero).
module sradd_lzc (
    input  logic [27:0] value,
    output logic [4:0]  count
);

    logic found;

    always_comb begin
        count = 5'd28;
        found = 1'b0;
        for (int i = 27; i >= 0; i--) begin
            if (!found && value[i]) begin
                count = 5'(27 - i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sradd.sv
// Single-precision adder, truncating, denormals flushed, one register stage.
module sradd
    import sp_fp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    output logic [31:0] z
);

    localparam logic signed [9:0] EXP_OVF = $signed({2'b00, EMAX});

    sp_t         fa, fb, fl, fs;
    logic        a_big;
    logic [7:0]  diff;
    logic [23:0] sig_l, sig_s;
    logic [52:0] shifted;
    logic [26:0] large_al, small_al;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [9:0]  exp_ext;
    logic signed [9:0] exp_res;
    logic [22:0] mant;
    logic [31:0] result;

    assign fa = a;
    assign fb = b;

    // Order operands by magnitude so the subtraction never goes negative.
    assign a_big = fa[30:0] >= fb[30:0];
    assign fl    = a_big ? fa : fb;
    assign fs    = a_big ? fb : fa;
    assign diff  = fl.exp - fs.exp;
    assign sig_l = {1'b1, fl.mant};
    assign sig_s = {1'b1, fs.mant};

    // 27-bit aligned significands: 24 bits plus guard, round and sticky.
    assign shifted  = {sig_s, 29'd0} >> diff;
    assign large_al = {sig_l, 3'b000};
    assign small_al = (diff > 8'd26) ? 27'd1 : {shifted[52:27], |shifted[26:0]};

    assign sum = (fl.sign != fs.sign) ? {1'b0, large_al} - {1'b0, small_al}
                                      : {1'b0, large_al} + {1'b0, small_al};

    sradd_lzc u_lzc (
        .value ({sum[26:0], 1'b0}),
        .count (lz)
    );

    always_comb begin
        exp_ext = sum[27] ? {2'b00, fl.exp} + 10'd1 : {2'b00, fl.exp} - {5'd0, lz};
        exp_res = signed'(exp_ext);
        mant    = sum[27] ? sum[26:4] : 23'((sum[25:0] << lz) >> 3);

        if (fa.exp == EMAX || fb.exp == EMAX)
            result = NAN;
        else if (fa.exp == 8'd0 && fb.exp == 8'd0)
            result = ZERO;
        else if (fa.exp == 8'd0)
            result = b;
        else if (fb.exp == 8'd0)
            result = a;
        else if (sum == 28'd0)
            result = ZERO;
        else if (exp_res >= EXP_OVF)
            result = NAN;
        else if (exp_res <= 10'sd0)
            result = ZERO;
        else
            result = {fl.sign, exp_res[7:0], mant};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            z         <= ZERO;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid)
                z <= result;
        end
    end

endmodule

// File: tb/tb_sradd.sv
// Table-driven bench for sradd with an in-order scoreboard on the output side.
module tb_sradd;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] a, b;
    logic        out_valid;
    logic [31:0] z;

    sradd dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .z         (z)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs[NV];
    logic [31:0] sb[$];
    logic [31:0] want;
    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Scoreboard side: every valid output must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset === 1'b0 && out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got z=%h with no operation outstanding", z);
            end else begin
                want = sb.pop_front();
                check("result", z, want);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{32'h3F800000, 32'h3F800000, 32'h40000000};
        vecs[1]  = '{32'h3F800000, 32'h3F3504F3, 32'h3FDA8279};
        vecs[2]  = '{32'h40000000, 32'hBF000000, 32'h3FC00000};
        vecs[3]  = '{32'h3F800000, 32'hBF800000, 32'h00000000};
        vecs[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'hFFFFFFFF};
        vecs[5]  = '{32'h00800000, 32'h80C00000, 32'h00000000};
        vecs[6]  = '{32'h3F800000, 32'h00000000, 32'h3F800000};
        vecs[7]  = '{32'h7F800000, 32'h3F800000, 32'hFFFFFFFF};
        vecs[8]  = '{32'h00000000, 32'hBF800000, 32'hBF800000};
        vecs[9]  = '{32'h00000000, 32'h80000000, 32'h00000000};
        vecs[10] = '{32'h3F800000, 32'h00400000, 32'h3F800000};
        vecs[11] = '{32'h3F800000, 32'h33800000, 32'h3F800000};
        vecs[12] = '{32'h3F800000, 32'hB3800000, 32'h3F7FFFFF};
        vecs[13] = '{32'h3F800000, 32'hBE800000, 32'h3F400000};
        vecs[14] = '{32'h3F800000, 32'hB0800000, 32'h3F7FFFFF};
        vecs[15] = '{32'h3FC00000, 32'h3FC00000, 32'h40400000};
        vecs[16] = '{32'hC0000000, 32'h3F800000, 32'hBF800000};
        vecs[17] = '{32'h00800000, 32'h80800001, 32'h00000000};
        vecs[18] = '{32'h7F000000, 32'h7F000000, 32'hFFFFFFFF};
        vecs[19] = '{32'h3F800000, 32'hFF800000, 32'hFFFFFFFF};
        vecs[20] = '{32'h7FC00000, 32'h00000000, 32'hFFFFFFFF};
        vecs[21] = '{32'hBF3504F3, 32'hBF800000, 32'hBFDA8279};

        reset = 1'b1;
        in_valid = 1'b0;
        a = 32'h0;
        b = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_z", z, 32'h0);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        reset = 1'b0;

        // Back-to-back burst: one operation per cycle, results in order.
        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            if (i > 0) check("burst_out_valid", {31'd0, out_valid}, 32'd1);
            a = vecs[i].a;
            b = vecs[i].b;
            in_valid = 1'b1;
            sb.push_back(vecs[i].z);
        end
        @(posedge clk);
        #1;
        check("burst_last_out_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        a = 32'h3F800000;
        b = 32'h3F800000;

        // Idle cycles: valid drops, z holds the last result.
        @(posedge clk);
        #1;
        check("idle_out_valid", {31'd0, out_valid}, 32'd0);
        check("idle_hold_z", z, vecs[NV-1].z);
        @(posedge clk);
        #1;
        check("idle_hold_z2", z, vecs[NV-1].z);

        // Reset on the same edge as an accepted operation discards it.
        a = 32'h3F800000;
        b = 32'h3F800000;
        in_valid = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_with_valid_z", z, 32'h0);
        check("reset_with_valid_out_valid", {31'd0, out_valid}, 32'd0);
        reset = 1'b0;

        // Isolated operations separated by a bubble.
        a = 32'h40000000;
        b = 32'hBF000000;
        sb.push_back(32'h3FC00000);
        @(posedge clk);
        #1;
        check("single_out_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("bubble_out_valid", {31'd0, out_valid}, 32'd0);
        check("bubble_hold_z", z, 32'h3FC00000);
        a = 32'hC0000000;
        b = 32'h3F800000;
        in_valid = 1'b1;
        sb.push_back(32'hBF800000);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sradd.md
SRADD -- requirements
Module: sradd

Interface
REQ-001 Parameters: none; widths fixed for IEEE-754 single precision.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  a/b carry a new operation this cycle.
REQ-005 a  input  32  addend, SP float (sign 31, exponent 30:23, mantissa 22:0).
REQ-006 b  input  32  addend, same format.
REQ-007 out_valid  output  1  z holds the result of the operation accepted one cycle earlier.
REQ-008 z  output  32  registered sum a+b.

Function
REQ-009 Latency SHALL be exactly 1 cycle: in_valid at edge N -> out_valid=1 and z valid after edge N; no backpressure, one operation accepted per cycle.
REQ-010 Without in_valid, out_valid SHALL drop to 0 and z SHALL hold its last value.
REQ-011 Operands with exponent 0 SHALL be treated as zero (denormals flushed).
REQ-012 Any operand with exponent 0xFF SHALL produce z=0xFFFFFFFF.
REQ-013 Both operands zero SHALL produce z=0x00000000.
REQ-014 If exactly one operand is zero, z SHALL be the other operand unchanged.
REQ-015 Hidden 1 restored; operands aligned to the larger exponent; magnitudes added for equal signs, subtracted for unequal signs.
REQ-016 Result magnitude SHALL equal the exact sum truncated toward zero to 24 significant bits; guard, round and sticky bits SHALL be kept so subtraction borrows correctly.
REQ-017 Result sign SHALL be the sign of the larger-magnitude operand; exact cancellation SHALL yield +0 (0x00000000).
REQ-018 Normalisation: carry out -> shift right 1, exponent +1; otherwise shift left by leading-zero count, exponent decreased by that count.
REQ-019 Result exponent >= 0xFF (overflow) SHALL produce z=0xFFFFFFFF.
REQ-020 Result exponent <= 0 (underflow) SHALL produce z=0x00000000.
REQ-021 Alignment shifts > 26 SHALL collapse the smaller operand into the sticky bit only.

Reset
REQ-022 reset=1 at a rising edge SHALL set z=0x00000000 and out_valid=0, overriding in_valid.
REQ-023 An operation accepted on the same edge reset is asserted SHALL be discarded.

Structure
REQ-024 Package sp_fp_pkg SHALL hold the field bit ranges, ZERO (32'h0), NaN (32'hFFFFFFFF), the bias (127) and EMAX (0xFF).
REQ-025 Leading-zero count SHALL be a sub-module sradd_lzc (28-bit in, 5-bit count out).
REQ-026 All arithmetic combinational before a single output register stage.

Verification
REQ-027 a=0x3F800000, b=0x3F800000 -> z=0x40000000 one cycle later, out_valid=1.
REQ-028 a=0x3F800000, b=0x3F3504F3 -> z=0x3FDA8279 (truncated, not 0x3FDA827A).
REQ-029 a=0x40000000, b=0xBF000000 -> z=0x3FC00000; a=0x3F800000, b=0xBF800000 -> z=0x00000000.
REQ-030 a=0x7F7FFFFF, b=0x7F7FFFFF -> z=0xFFFFFFFF; a=0x00800000, b=0x80C00000 -> z=0x00000000.
REQ-031 a=0x3F800000, b=0x00000000 -> z=0x3F800000; a=0x7F800000, any b -> z=0xFFFFFFFF.
REQ-032 Reset asserted together with in_valid -> after edge z=0x00000000, out_valid=0; back-to-back in_valid each cycle -> one result per cycle, in order.
